// File: rtl/color_pkg.sv
// Shared colour-format constants for the RGB444 <-> RGB222 scaler and quantizer.
package color_pkg;

  // A 2-bit code d expands to the 4-bit level {d,d}, i.e. d * LEVEL_STEP.
  localparam int unsigned LEVEL_STEP = 5;
  localparam int unsigned CH_IN_W    = 4;
  localparam int unsigned CH_OUT_W   = 2;
  localparam int unsigned ERR_W      = 3;
  localparam int unsigned SUM_W      = 6;
  localparam int unsigned CH_IN_MAX  = (1 << CH_IN_W) - 1;

  localparam int unsigned RGB444_W   = 3 * CH_IN_W;
  localparam int unsigned RGB222_W   = 3 * CH_OUT_W;

  // Field offsets within the packed pixel words.
  localparam int unsigned R444_LSB   = 2 * CH_IN_W;
  localparam int unsigned G444_LSB   = CH_IN_W;
  localparam int unsigned B444_LSB   = 0;
  localparam int unsigned R222_LSB   = 2 * CH_OUT_W;
  localparam int unsigned G222_LSB   = CH_OUT_W;
  localparam int unsigned B222_LSB   = 0;

endpackage

// File: rtl/quant_channel.sv
// One colour channel: add diffused error, clamp, pick nearest level, report residual.
module quant_channel
  import color_pkg::*;
(
  input  logic [CH_IN_W-1:0]      i_v,
  input  logic signed [ERR_W-1:0] i_e,
  output logic [CH_OUT_W-1:0]     o_q_c,
  output logic signed [ERR_W-1:0] o_r_c
);

  logic signed [SUM_W-1:0] w_s;
  logic [CH_IN_W-1:0]      w_sc;
  logic [SUM_W-1:0]        w_t;
  logic [SUM_W-1:0]        w_lvl;

  // Error-adjusted sample; the error is sign-extended, the input is not.
  assign w_s = $signed(SUM_W'(i_v)) + SUM_W'(i_e);

  // Saturate the adjusted sample back into the 4-bit input range.
  always_comb begin
    w_sc = CH_IN_W'(w_s);
    if (w_s[SUM_W-1]) begin
      w_sc = '0;
    end else if (w_s > $signed(SUM_W'(CH_IN_MAX))) begin
      w_sc = CH_IN_W'(CH_IN_MAX);
    end
  end

  // Biasing by half a step before the divide rounds to the nearest level.
  assign w_t   = SUM_W'(w_sc) + SUM_W'(LEVEL_STEP / 2);
  assign o_q_c = CH_OUT_W'(w_t / SUM_W'(LEVEL_STEP));
  assign w_lvl = SUM_W'(o_q_c) * SUM_W'(LEVEL_STEP);
  assign o_r_c = ERR_W'(SUM_W'(w_sc) - w_lvl);

endmodule

// File: rtl/color_quantizer.sv
// RGB444 -> RGB222 quantizer with optional per-line 1-D error diffusion.
module color_quantizer
  import color_pkg::*;
#(
  parameter bit DITHER_DEFAULT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dither_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RGB444_W-1:0] in_data,
  input  logic                in_sol,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RGB222_W-1:0] out_data,
  output logic                out_sol
);

  logic                    r_out_valid;
  logic [RGB222_W-1:0]     r_out_data;
  logic                    r_out_sol;
  logic signed [ERR_W-1:0] r_err_r;
  logic signed [ERR_W-1:0] r_err_g;
  logic signed [ERR_W-1:0] r_err_b;

  logic                    w_accept;
  logic                    w_dither;
  logic [RGB222_W-1:0]     w_q;
  logic [CH_OUT_W-1:0]     w_q_r, w_q_g, w_q_b;
  logic signed [ERR_W-1:0] w_r_r, w_r_g, w_r_b;
  logic signed [ERR_W-1:0] w_e_r, w_e_g, w_e_b;

  // DITHER_DEFAULT only records integration intent; the port is authoritative.
  if (DITHER_DEFAULT) begin : g_dither_default_on
    assign w_dither = dither_en;
  end else begin : g_dither_default_off
    assign w_dither = dither_en;
  end

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sol   = r_out_sol;

  // Start of line discards carried error so it never crosses lines.
  assign w_e_r = in_sol ? '0 : r_err_r;
  assign w_e_g = in_sol ? '0 : r_err_g;
  assign w_e_b = in_sol ? '0 : r_err_b;

  quant_channel u_ch_r (
    .i_v   (in_data[R444_LSB +: CH_IN_W]),
    .i_e   (w_e_r),
    .o_q_c (w_q_r),
    .o_r_c (w_r_r)
  );

  quant_channel u_ch_g (
    .i_v   (in_data[G444_LSB +: CH_IN_W]),
    .i_e   (w_e_g),
    .o_q_c (w_q_g),
    .o_r_c (w_r_g)
  );

  quant_channel u_ch_b (
    .i_v   (in_data[B444_LSB +: CH_IN_W]),
    .i_e   (w_e_b),
    .o_q_c (w_q_b),
    .o_r_c (w_r_b)
  );

  assign w_q[R222_LSB +: CH_OUT_W] = w_q_r;
  assign w_q[G222_LSB +: CH_OUT_W] = w_q_g;
  assign w_q[B222_LSB +: CH_OUT_W] = w_q_b;

  // Output slot and error registers; both advance only on an accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sol   <= 1'b0;
      r_err_r     <= '0;
      r_err_g     <= '0;
      r_err_b     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_q;
      r_out_sol   <= in_sol;
      r_err_r     <= w_dither ? w_r_r : '0;
      r_err_g     <= w_dither ? w_r_g : '0;
      r_err_b     <= w_dither ? w_r_b : '0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_color_quantizer.sv
// Directed and random stimulus against a nearest-level reference model.
module tb_color_quantizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dither_en;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        in_sol;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_data;
  logic        out_sol;

  always #5 clk = ~clk;

  color_quantizer #(.DITHER_DEFAULT(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .dither_en (dither_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sol    (in_sol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sol   (out_sol)
  );

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         me[3];
  logic [6:0] exp_q[$];   // pending outputs as {sol, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Nearest of levels 0,5,10,15 to the clamped sum; residual is the distance signed.
  function automatic void quant(input int v, input int e, output int q, output int r);
    int s;
    int best;
    s = v + e;
    if (s < 0)  s = 0;
    if (s > 15) s = 15;
    best = 0;
    for (int k = 1; k < 4; k++) begin
      if (((s - 5*k) < 0 ? (5*k - s) : (s - 5*k)) < ((s - 5*best) < 0 ? (5*best - s) : (s - 5*best)))
        best = k;
    end
    q = best;
    r = s - 5*best;
  endfunction

  // One clock: drive inputs, check observable state against model, advance model.
  task automatic step(input bit rst, input bit vld, input logic [11:0] d,
                      input bit sol, input bit de, input bit ordy);
    bit         acc;
    bit         drn;
    bit         have;
    logic [5:0] od;
    int         q;
    int         r;
    int         v;
    int         ein;
    reset     = rst;
    in_valid  = vld;
    in_data   = d;
    in_sol    = sol;
    dither_en = de;
    out_ready = ordy;
    #1;
    have = (exp_q.size() != 0);
    chk("out_valid", {31'b0, out_valid}, {31'b0, have});
    if (have) begin
      chk("out_data", {26'b0, out_data}, {26'b0, exp_q[0][5:0]});
      chk("out_sol",  {31'b0, out_sol},  {31'b0, exp_q[0][6]});
    end
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!have || ordy)});
    chk("err_r", {29'b0, dut.r_err_r}, 32'(me[0]) & 32'h7);
    chk("err_g", {29'b0, dut.r_err_g}, 32'(me[1]) & 32'h7);
    chk("err_b", {29'b0, dut.r_err_b}, 32'(me[2]) & 32'h7);
    acc = !rst && vld && (!have || ordy);
    drn = !rst && have && ordy;
    if (drn) void'(exp_q.pop_front());
    if (acc) begin
      od = '0;
      for (int c = 0; c < 3; c++) begin
        v   = int'((d >> (4 * (2 - c))) & 12'hF);
        ein = sol ? 0 : me[c];
        quant(v, ein, q, r);
        od    = od | 6'(q << (2 * (2 - c)));
        me[c] = de ? r : 0;
      end
      exp_q.push_back({sol, od});
    end
    if (rst) begin
      exp_q.delete();
      me = '{0, 0, 0};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    me        = '{0, 0, 0};
    reset     = 1'b1;
    dither_en = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sol    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset held once more under checking, then released.
    step(1, 0, 12'h000, 0, 1, 1);

    // Round trip of exact levels, each as its own line.
    step(0, 1, 12'h000, 1, 1, 1);
    step(0, 1, 12'h555, 1, 1, 1);
    step(0, 1, 12'hAAA, 1, 1, 1);
    step(0, 1, 12'hFFF, 1, 1, 1);
    step(0, 0, 12'h000, 0, 1, 1);

    // Diffusion along a line of mid-grey.
    step(0, 1, 12'h777, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 12'h777, 0, 1, 1);
    step(0, 0, 12'h000, 0, 1, 1);

    // Clamp on a single channel: 12 then 15.
    step(0, 1, 12'hC00, 1, 1, 1);
    step(0, 1, 12'hF00, 0, 1, 1);
    step(0, 0, 12'h000, 0, 1, 1);

    // Plain rounding.
    for (int i = 0; i < 4; i++) step(0, 1, 12'h777, (i == 0), 0, 1);
    step(0, 0, 12'h000, 0, 0, 1);

    // Backpressure mid-stream.
    step(0, 1, 12'h369, 1, 1, 1);
    step(0, 1, 12'h8AE, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 12'h4B2, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 12'(32'h123 * (i + 3)), 0, 1, 1);
    step(0, 0, 12'h000, 0, 1, 1);

    // Random traffic with mid-line dither changes and random stalls.
    for (int i = 0; i < 300; i++) begin
      step(0, ($urandom_range(0, 3) != 0), 12'($urandom), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    // Reset while the output slot holds an undelivered pixel.
    step(0, 1, 12'h777, 1, 1, 1);
    step(0, 1, 12'h777, 0, 1, 0);
    step(1, 1, 12'h777, 0, 1, 0);
    step(0, 1, 12'h777, 0, 1, 1);
    chk("post_rst_data", {26'b0, out_data}, 32'h15);
    step(0, 0, 12'h000, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
